// File: rtl/dp_ram_pipe.sv
// Dual-port (1W/1R) byte-writable RAM with a RD_LATENCY-deep read pipeline.
// Out-of-range accesses are flagged (rd_err with the read result, wr_err
// one cycle after a dropped write). Memory contents survive reset.

// Per-byte select: new byte when enabled, otherwise the old byte.
module dp_ram_pipe_lane (
   input  logic [7:0] old_byte,
   input  logic [7:0] new_byte,
   input  logic       en,
   output logic [7:0] merged
);
   assign merged = en ? new_byte : old_byte;
endmodule

module dp_ram_pipe #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 12,
   parameter int DEPTH      = 4096,
   parameter int RD_LATENCY = 1,
   parameter int RW_MODE    = 0
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    write,
   input  logic [ADDR_WIDTH-1:0]   wr_address,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic [DATA_WIDTH/8-1:0] byte_en,
   input  logic                    read,
   input  logic [ADDR_WIDTH-1:0]   rd_address,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    data_valid,
   output logic                    rd_err,
   output logic                    wr_err
);

   localparam int NB = DATA_WIDTH / 8;
   // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  wr_in_range;
   logic                  rd_in_range;
   logic                  collide;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] fwd_word;
   logic [DATA_WIDTH-1:0] rd_data0;

   // Stage s holds a read sampled s edges ago; stage RD_LATENCY drives the outputs.
   logic [RD_LATENCY:1]   vld_pipe;
   logic [RD_LATENCY:1]   err_pipe;
   logic [DATA_WIDTH-1:0] data_pipe [1:RD_LATENCY];

   assign wr_in_range = ({1'b0, wr_address} < DEPTH_W);
   assign rd_in_range = ({1'b0, rd_address} < DEPTH_W);

   // Array reads return the pre-edge word, so read-old needs no extra logic.
   assign rd_word = rd_in_range ? mem[rd_address] : '0;

   // Write-first forwarding: overlay the enabled bytes of the incoming write.
   for (genvar i = 0; i < NB; i++) begin : g_lane
      dp_ram_pipe_lane u_lane (
         .old_byte (rd_word[8*i +: 8]),
         .new_byte (data_in[8*i +: 8]),
         .en       (byte_en[i]),
         .merged   (fwd_word[8*i +: 8])
      );
   end

   assign collide  = (RW_MODE == 1) && write && wr_in_range && rd_in_range &&
                     (wr_address == rd_address);
   assign rd_data0 = collide ? fwd_word : rd_word;

   // Byte-masked write; memory is never reset, requests ignored while in reset.
   always_ff @(posedge clock) begin
      if (resetn && write && wr_in_range) begin
         for (int i = 0; i < NB; i++) begin
            if (byte_en[i]) mem[wr_address][8*i +: 8] <= data_in[8*i +: 8];
         end
      end
   end

   // Read pipeline; data stages only load behind a valid, so data_out holds.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         vld_pipe <= '0;
         err_pipe <= '0;
         for (int s = 1; s <= RD_LATENCY; s++) data_pipe[s] <= '0;
      end else begin
         vld_pipe[1] <= read;
         err_pipe[1] <= read & ~rd_in_range;
         if (read) data_pipe[1] <= rd_data0;
         for (int s = 2; s <= RD_LATENCY; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            err_pipe[s] <= err_pipe[s-1];
            if (vld_pipe[s-1]) data_pipe[s] <= data_pipe[s-1];
         end
      end
   end

   // Dropped-write flag; an all-zero byte_en is a no-op and never an error.
   always_ff @(posedge clock) begin
      if (!resetn) wr_err <= 1'b0;
      else         wr_err <= write && (|byte_en) && !wr_in_range;
   end

   assign data_out   = data_pipe[RD_LATENCY];
   assign data_valid = vld_pipe[RD_LATENCY];
   assign rd_err     = err_pipe[RD_LATENCY];

   a_byte_en_known: assert property (@(posedge clock) disable iff (!resetn)
      write |-> !$isunknown(byte_en));

endmodule

// File: tb/tb_dp_ram_pipe.sv
// Random + directed bench for dp_ram_pipe. Two instances share one stimulus:
// u_old (read-old, latency 2) and u_new (write-first, latency 3), both with
// DEPTH=3000. Expected read results are scheduled by absolute delivery cycle.
module tb_dp_ram_pipe;

   localparam int DW    = 64;
   localparam int AW    = 12;
   localparam int DEPTH = 3000;
   localparam int NS    = 4096;

   logic          clock = 1'b0;
   logic          resetn, write, read;
   logic [AW-1:0] wa, ra;
   logic [DW-1:0] din;
   logic [7:0]    be;

   logic [DW-1:0] dout0, dout1;
   logic          dv0, dv1, re0, re1, we0, we1;

   int lat [2] = '{2, 3};

   // reference state
   logic [DW-1:0] mm [0:DEPTH-1];
   bit            sv [2][NS];
   bit            se [2][NS];
   logic [DW-1:0] sd [2][NS];
   logic [DW-1:0] last [2];
   logic          exp_we;
   int            cyc;
   int            n_chk, n_fail;

   always #5 clock = ~clock;

   dp_ram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                 .RD_LATENCY(2), .RW_MODE(0)) u_old (
      .clock(clock), .resetn(resetn), .write(write), .wr_address(wa),
      .data_in(din), .byte_en(be), .read(read), .rd_address(ra),
      .data_out(dout0), .data_valid(dv0), .rd_err(re0), .wr_err(we0));

   dp_ram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                 .RD_LATENCY(3), .RW_MODE(1)) u_new (
      .clock(clock), .resetn(resetn), .write(write), .wr_address(wa),
      .data_in(din), .byte_en(be), .read(read), .rd_address(ra),
      .data_out(dout1), .data_valid(dv1), .rd_err(re1), .wr_err(we1));

   task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // What a read of ra sampled now should return for instance d.
   function automatic logic [DW-1:0] rd_model(int d);
      logic [DW-1:0] r;
      if (ra >= DEPTH) return '0;
      r = mm[ra];
      if (d == 1 && write && wa == ra && wa < DEPTH)
         for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = din[8*b +: 8];
      return r;
   endfunction

   task automatic chk_dut(int d, logic dv, logic re, logic [DW-1:0] dout, logic we);
      string p;
      p = (d == 0) ? "old" : "new";
      if (sv[d][cyc]) begin
         last[d] = sd[d][cyc];
         chk({p, "_valid"}, DW'(dv), 64'd1);
         chk({p, "_rd_err"}, DW'(re), DW'(se[d][cyc]));
      end else begin
         chk({p, "_valid"}, DW'(dv), 64'd0);
         chk({p, "_rd_err"}, DW'(re), 64'd0);
      end
      chk({p, "_data"}, dout, last[d]);
      chk({p, "_wr_err"}, DW'(we), DW'(exp_we));
   endtask

   // One clock edge: update the reference with the sampled inputs, then check.
   task automatic tick();
      @(posedge clock);
      if (!resetn) begin
         for (int d = 0; d < 2; d++) begin
            for (int k = cyc; k < cyc + 4 && k < NS; k++) sv[d][k] = 1'b0;
            last[d] = '0;
         end
         exp_we = 1'b0;
      end else begin
         if (read)
            for (int d = 0; d < 2; d++) begin
               sv[d][cyc + lat[d] - 1] = 1'b1;
               se[d][cyc + lat[d] - 1] = (ra >= DEPTH);
               sd[d][cyc + lat[d] - 1] = rd_model(d);
            end
         if (write && wa < DEPTH)
            for (int b = 0; b < 8; b++) if (be[b]) mm[wa][8*b +: 8] = din[8*b +: 8];
         exp_we = write && (be != 8'h00) && (wa >= DEPTH);
      end
      #1;
      chk_dut(0, dv0, re0, dout0, we0);
      chk_dut(1, dv1, re1, dout1, we1);
      cyc++;
   endtask

   task automatic idle(int n);
      write = 1'b0; read = 1'b0; be = '0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_wr(logic [AW-1:0] a, logic [DW-1:0] d, logic [7:0] b);
      write = 1'b1; wa = a; din = d; be = b; read = 1'b0;
      tick();
      write = 1'b0; be = '0;
   endtask

   task automatic do_rd(logic [AW-1:0] a);
      read = 1'b1; ra = a; write = 1'b0;
      tick();
      read = 1'b0;
   endtask

   initial begin
      n_chk = 0; n_fail = 0; cyc = 0;
      last[0] = '0; last[1] = '0; exp_we = 1'b0;
      resetn = 1'b0; write = 1'b1; read = 1'b1; wa = '0; ra = '0; din = '1; be = 8'hFF;
      tick(); tick();   // requests present during reset must be ignored
      resetn = 1'b1;
      idle(1);

      // preload the working set 0..63
      for (int a = 0; a < 64; a++) do_wr(AW'(a), {$urandom, $urandom}, 8'hFF);

      // byte-enable merge
      do_wr(12'h010, 64'h1122334455667788, 8'hFF);
      do_wr(12'h010, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
      do_rd(12'h010);
      idle(4);
      chk("be_merge_old", dout0, 64'h11223344AAAAAAAA);
      chk("be_merge_new", dout1, 64'h11223344AAAAAAAA);

      // streaming reads
      for (int a = 0; a < 4; a++) begin
         read = 1'b1; ra = AW'(a); tick();
      end
      idle(4);
      chk("stream_last_old", dout0, mm[3]);

      // collision
      do_wr(12'h005, 64'hA, 8'hFF);
      write = 1'b1; wa = 12'h005; din = 64'hB; be = 8'hFF; read = 1'b1; ra = 12'h005;
      tick();
      idle(4);
      chk("collide_old", dout0, 64'hA);
      chk("collide_new", dout1, 64'hB);
      do_rd(12'h005);
      idle(4);
      chk("after_collide", dout0, 64'hB);

      // out of range
      do_wr(12'hBB8, 64'hDEAD, 8'hFF);
      chk("wr_err_pulse", DW'(we0), 64'd1);
      idle(1);
      chk("wr_err_clear", DW'(we0), 64'd0);
      do_rd(12'hFFF);
      idle(1);
      chk("oor_rd_err", DW'(re0), 64'd1);
      chk("oor_rd_data", dout0, 64'd0);
      idle(3);

      // reset while reads are in flight
      do_rd(12'h001);
      do_rd(12'h002);
      resetn = 1'b0; read = 1'b1; ra = 12'h003;
      tick();
      resetn = 1'b1;
      idle(5);
      do_rd(12'h010);
      idle(4);
      chk("post_reset_old", dout0, 64'h11223344AAAAAAAA);
      chk("post_reset_new", dout1, 64'h11223344AAAAAAAA);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         resetn = ($urandom_range(0, 199) != 0);
         write  = $urandom_range(0, 1) == 1;
         wa     = ($urandom_range(0, 7) == 0) ? AW'(DEPTH + $urandom_range(0, 1095))
                                              : AW'($urandom_range(0, 63));
         din    = {$urandom, $urandom};
         be     = 8'($urandom);
         if (wa >= DEPTH && be == 8'h00) be = 8'h01;
         read   = $urandom_range(0, 3) != 0;
         ra     = ($urandom_range(0, 3) == 0) ? wa :
                  ($urandom_range(0, 9) == 0) ? AW'(DEPTH + $urandom_range(0, 1095))
                                              : AW'($urandom_range(0, 63));
         tick();
      end
      resetn = 1'b1;
      idle(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
